// File: rtl/uart_bus_pkg.sv
// Shared command codes, reply defaults and FSM encoding for the
// UART-to-bus bridge.
`timescale 1ns/1ps
package uart_bus_pkg;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] CMD_IOWR = 8'h4F;
  localparam logic [7:0] CMD_IORD = 8'h49;
  localparam logic [7:0] ACK_DEF  = 8'h06;
  localparam logic [7:0] NAK_DEF  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR2,
    S_ADDR1,
    S_ADDR0,
    S_DATA,
    S_BUS,
    S_RDWAIT,
    S_REPLY
  } state_e;

endpackage

// File: rtl/uart_bus_master_if.sv
// Byte-stream and bus signals of the UART bus master, grouped so the
// parent wires uartRx, uartTx and the bus arbiter through one bundle.
`timescale 1ns/1ps
interface uart_bus_master_if;
  logic [7:0]  iRxData;
  logic        iRxValid;
  logic [7:0]  oTxData;
  logic        oTxStart;
  logic        iTxReady;
  logic [19:0] oAddr;
  logic        oWr;
  logic        oRd;
  logic [7:0]  oWrData;
  logic        oIo;
  logic        iGnt;
  logic [7:0]  iRdData;
  logic        oErr;

  modport master (
    input  iRxData, iRxValid, iTxReady, iGnt, iRdData,
    output oTxData, oTxStart, oAddr, oWr, oRd, oWrData, oIo, oErr
  );

  modport slave (
    output iRxData, iRxValid, iTxReady, iGnt, iRdData,
    input  oTxData, oTxStart, oAddr, oWr, oRd, oWrData, oIo, oErr
  );
endinterface

// File: rtl/uart_bus_master.sv
// UART command bridge: 'W'/'R' frames become one bus cycle plus a reply.
// Define UART_BUS_MASTER_IO_EN to also accept 'O'/'I' I/O-space frames.
`timescale 1ns/1ps
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 500000,
  parameter logic [7:0]  ACK     = ACK_DEF,
  parameter logic [7:0]  NAK     = NAK_DEF
) (
  input logic iClk,
  input logic iRstN,
  uart_bus_master_if.master bus
);

  localparam logic [23:0] TO_LAST = 24'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  reply_q, reply_d;
  logic [23:0] cnt_q, cnt_d;
  logic        wr_cmd_q, wr_cmd_d;
  logic        io_cmd_q, io_cmd_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        io_q, io_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        err_q, err_d;
  logic [1:0]  sync_q;
  logic        rst_ok;

  assign rst_ok       = sync_q[1];
  assign bus.oAddr    = addr_q;
  assign bus.oWrData  = wdata_q;
  assign bus.oWr      = wr_q;
  assign bus.oRd      = rd_q;
  assign bus.oIo      = io_q;
  assign bus.oTxStart = tx_start_q;
  assign bus.oTxData  = tx_data_q;
  assign bus.oErr     = err_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    reply_d    = reply_q;
    cnt_d      = cnt_q;
    wr_cmd_d   = wr_cmd_q;
    io_cmd_d   = io_cmd_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    io_d       = io_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.iRxValid && rst_ok) begin
          addr_d = '0;
          unique case (1'b1)
            (bus.iRxData == CMD_WR),
            (bus.iRxData == CMD_RD): begin
              state_d  = S_ADDR2;
              wr_cmd_d = (bus.iRxData == CMD_WR);
              io_cmd_d = 1'b0;
            end
`ifdef UART_BUS_MASTER_IO_EN
            (bus.iRxData == CMD_IOWR),
            (bus.iRxData == CMD_IORD): begin
              state_d  = S_ADDR1;
              wr_cmd_d = (bus.iRxData == CMD_IOWR);
              io_cmd_d = 1'b1;
            end
`endif
            default: begin
              state_d = S_REPLY;
              reply_d = NAK;
            end
          endcase
        end
      end
      S_ADDR2, S_ADDR1, S_ADDR0, S_DATA: begin
        // an arriving byte beats a same-cycle timeout
        if (bus.iRxValid) begin
          cnt_d = '0;
          unique case (state_q)
            S_ADDR2: begin
              addr_d[19:16] = bus.iRxData[3:0];
              state_d       = S_ADDR1;
            end
            S_ADDR1: begin
              addr_d[15:8] = bus.iRxData;
              state_d      = S_ADDR0;
            end
            S_ADDR0: begin
              addr_d[7:0] = bus.iRxData;
              if (wr_cmd_q) begin
                state_d = S_DATA;
              end else begin
                state_d = S_BUS;
                rd_d    = 1'b1;
                io_d    = io_cmd_q;
              end
            end
            default: begin
              wdata_d = bus.iRxData;
              state_d = S_BUS;
              wr_d    = 1'b1;
              io_d    = io_cmd_q;
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      S_BUS: begin
        err_d = bus.iRxValid;
        if (bus.iGnt) begin
          wr_d = 1'b0;
          rd_d = 1'b0;
          io_d = 1'b0;
          if (wr_cmd_q) begin
            state_d = S_REPLY;
            reply_d = ACK;
          end else begin
            state_d = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        err_d   = bus.iRxValid;
        reply_d = bus.iRdData;
        state_d = S_REPLY;
      end
      S_REPLY: begin
        err_d = bus.iRxValid;
      end
      default: state_d = S_IDLE;
    endcase
    // send straight away when the transmitter is free
    if (state_d == S_REPLY && bus.iTxReady) begin
      tx_start_d = 1'b1;
      tx_data_d  = reply_d;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      reply_q    <= '0;
      cnt_q      <= '0;
      wr_cmd_q   <= 1'b0;
      io_cmd_q   <= 1'b0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      io_q       <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      reply_q    <= reply_d;
      cnt_q      <= cnt_d;
      wr_cmd_q   <= wr_cmd_d;
      io_cmd_q   <= io_cmd_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      io_q       <= io_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      err_q      <= err_d;
    end
  end

endmodule
